// File: rtl/impor_pkg.sv
// Shared types and default parameters for the IMPOR job scheduler.
package impor_pkg;

   localparam int BURST_DEFAULT   = 6;
   localparam int TIMEOUT_DEFAULT = 64;

   typedef logic [2:0] word_t;

   typedef enum logic [2:0] {
      IDLE,
      SEND,
      WAIT,
      RECV,
      DONE
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer hands priority to the non-owner
// whenever the scheduler signals that a job is finishing.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   input  logic       owner,
   output logic       grant,
   output logic       grant_valid
);

   logic ptr_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_reg <= 1'b0;
      end else if (advance) begin
         ptr_reg <= ~owner;
      end
   end

   // The pointer only matters when both requesters contend.
   assign grant_valid = |req;
   assign grant       = (&req) ? ptr_reg : req[1];

endmodule

// File: rtl/impor_sched.sv
// Shares one IMPOR engine between two requesters: grants a job, streams a
// fixed burst in, then forwards the engine's result words back to the owner.
module impor_sched
   import impor_pkg::*;
#(
   parameter int BURST   = BURST_DEFAULT,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  req0_valid,
   input  word_t req0_mode,
   input  word_t req0_data,
   output logic  req0_pop,
   input  logic  req1_valid,
   input  word_t req1_mode,
   input  word_t req1_data,
   output logic  req1_pop,
   output logic  rsp0_valid,
   output word_t rsp0_data,
   output logic  rsp0_done,
   output logic  rsp0_err,
   output logic  rsp1_valid,
   output word_t rsp1_data,
   output logic  rsp1_done,
   output logic  rsp1_err,
   output word_t eng_in,
   output word_t eng_mode,
   output logic  eng_in_valid,
   input  logic  eng_ready,
   input  word_t eng_out,
   input  logic  eng_out_valid,
   output logic  busy
);

   localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);
   localparam logic [TW-1:0] WAIT_LAST  = TW'(TIMEOUT - 1);

   state_t           state_reg;
   logic             owner_reg;
   word_t            mode_reg;
   logic [BW-1:0]    burst_cnt_reg;
   logic [TW-1:0]    wait_cnt_reg;
   logic [1:0]       rsp_valid_reg;
   logic [1:0][2:0]  rsp_data_reg;
   logic [1:0]       done_reg;
   logic [1:0]       err_reg;
   logic             busy_reg;
   logic             grant;
   logic             grant_valid;
   logic             to_done;
   logic [1:0]       pop_vec;

   // Either a quiet RECV cycle or an expired WAIT closes the job.
   assign to_done = ((state_reg == WAIT) && !eng_out_valid && (wait_cnt_reg == WAIT_LAST))
                 || ((state_reg == RECV) && !eng_out_valid);

   rr_arb2 u_arb (
      .clk         (clk),
      .rst         (rst),
      .req         ({req1_valid, req0_valid}),
      .advance     (to_done),
      .owner       (owner_reg),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_req
         assign pop_vec[gi] = (state_reg == SEND) && (owner_reg == 1'(gi));
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         owner_reg     <= 1'b0;
         mode_reg      <= '0;
         burst_cnt_reg <= '0;
         wait_cnt_reg  <= '0;
         rsp_valid_reg <= '0;
         rsp_data_reg  <= '0;
         done_reg      <= '0;
         err_reg       <= '0;
         busy_reg      <= 1'b0;
      end else begin
         rsp_valid_reg <= '0;
         rsp_data_reg  <= '0;
         done_reg      <= '0;
         err_reg       <= '0;
         case (state_reg)
            IDLE: begin
               if (eng_ready && grant_valid) begin
                  owner_reg     <= grant;
                  mode_reg      <= grant ? req1_mode : req0_mode;
                  burst_cnt_reg <= '0;
                  busy_reg      <= 1'b1;
                  state_reg     <= SEND;
               end
            end
            SEND: begin
               if (burst_cnt_reg == BURST_LAST) begin
                  wait_cnt_reg <= '0;
                  state_reg    <= WAIT;
               end else begin
                  burst_cnt_reg <= burst_cnt_reg + 1'b1;
               end
            end
            WAIT: begin
               if (eng_out_valid) begin
                  rsp_valid_reg[owner_reg] <= 1'b1;
                  rsp_data_reg[owner_reg]  <= eng_out;
                  state_reg                <= RECV;
               end else if (to_done) begin
                  done_reg[owner_reg] <= 1'b1;
                  err_reg[owner_reg]  <= 1'b1;
                  state_reg           <= DONE;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 1'b1;
               end
            end
            RECV: begin
               if (eng_out_valid) begin
                  rsp_valid_reg[owner_reg] <= 1'b1;
                  rsp_data_reg[owner_reg]  <= eng_out;
               end else begin
                  done_reg[owner_reg] <= 1'b1;
                  state_reg           <= DONE;
               end
            end
            DONE: begin
               mode_reg  <= '0;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign req0_pop     = pop_vec[0];
   assign req1_pop     = pop_vec[1];
   assign eng_in_valid = (state_reg == SEND);
   assign eng_in       = (state_reg == SEND) ? (owner_reg ? req1_data : req0_data) : '0;
   assign eng_mode     = mode_reg;
   assign busy         = busy_reg;
   assign rsp0_valid   = rsp_valid_reg[0];
   assign rsp1_valid   = rsp_valid_reg[1];
   assign rsp0_data    = rsp_data_reg[0];
   assign rsp1_data    = rsp_data_reg[1];
   assign rsp0_done    = done_reg[0];
   assign rsp1_done    = done_reg[1];
   assign rsp0_err     = err_reg[0];
   assign rsp1_err     = err_reg[1];

endmodule

// File: tb/tb_impor_sched.sv
// Directed bench for impor_sched: a scoreboard holds the result words each
// requester should see, while the main sequence checks timing of each job.
module tb_impor_sched;
   import impor_pkg::*;

   localparam int BURST   = 6;
   localparam int TIMEOUT = 64;

   logic clk = 1'b0;
   logic rst;
   logic req0_valid, req1_valid;
   logic [2:0] req0_mode, req1_mode, req0_data, req1_data;
   logic req0_pop, req1_pop;
   logic rsp0_valid, rsp1_valid;
   logic [2:0] rsp0_data, rsp1_data;
   logic rsp0_done, rsp1_done, rsp0_err, rsp1_err;
   logic [2:0] eng_in, eng_mode, eng_out;
   logic eng_in_valid, eng_ready, eng_out_valid, busy;

   int errors = 0;
   int checks = 0;
   int dones  = 0;
   int dones_before;
   logic [2:0] q0[$];
   logic [2:0] q1[$];

   always #5 clk = ~clk;

   impor_sched #(.BURST(BURST), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_mode(req0_mode), .req0_data(req0_data), .req0_pop(req0_pop),
      .req1_valid(req1_valid), .req1_mode(req1_mode), .req1_data(req1_data), .req1_pop(req1_pop),
      .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_done(rsp0_done), .rsp0_err(rsp0_err),
      .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_done(rsp1_done), .rsp1_err(rsp1_err),
      .eng_in(eng_in), .eng_mode(eng_mode), .eng_in_valid(eng_in_valid), .eng_ready(eng_ready),
      .eng_out(eng_out), .eng_out_valid(eng_out_valid), .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: every result word must match the next queued word.
   always @(negedge clk) begin
      if (rsp0_valid === 1'b1) begin
         if (q0.size() == 0) check("rsp0_unexpected", 32'(rsp0_valid), 0);
         else                check("rsp0_data", 32'(rsp0_data), 32'(q0.pop_front()));
      end
      if (rsp1_valid === 1'b1) begin
         if (q1.size() == 0) check("rsp1_unexpected", 32'(rsp1_valid), 0);
         else                check("rsp1_data", 32'(rsp1_data), 32'(q1.pop_front()));
      end
      if (rsp0_done === 1'b1 || rsp1_done === 1'b1) dones++;
   end

   // One job: wait for the grant, check the burst, play the engine, check done.
   task automatic run_job(input int own, input logic [2:0] mode, input bit stray,
                          input int delay, input int nwords, input bit tmo,
                          input logic [2:0] base, input string name);
      int n;
      logic [2:0] w;
      int own_bits;
      own_bits = own ? 2 : 1;
      n = 0;
      @(negedge clk);
      while (eng_in_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({name, "_grant"}, 32'(eng_in_valid), 1);
      if (stray) eng_out_valid = 1'b1;
      for (int i = 0; i < BURST; i++) begin
         check({name, "_pop"}, 32'({req1_pop, req0_pop}), 32'(own_bits));
         check({name, "_eng_in"}, 32'(eng_in), 32'(3'(base + 3'(i))));
         check({name, "_eng_mode"}, 32'(eng_mode), 32'(mode));
         @(posedge clk);
         #1;
         if (own == 0) req0_data = 3'(base + 3'(i + 1));
         else          req1_data = 3'(base + 3'(i + 1));
         if (i == BURST - 1) begin
            if (own == 0) req0_valid = 1'b0;
            else          req1_valid = 1'b0;
            eng_out_valid = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
      @(negedge clk);
      check({name, "_wait_quiet"}, 32'({eng_in_valid, req1_pop, req0_pop}), 0);
      check({name, "_wait_busy"}, 32'(busy), 1);
      if (tmo) begin
         for (int c = 1; c <= TIMEOUT; c++) begin
            @(negedge clk);
            if (c == TIMEOUT - 1) check({name, "_early_done"}, 32'({rsp1_done, rsp0_done}), 0);
         end
      end else begin
         repeat (delay) begin
            @(posedge clk);
            #1;
         end
         for (int j = 0; j < nwords; j++) begin
            w = 3'(j * 3 + own + 1);
            eng_out = w;
            eng_out_valid = 1'b1;
            if (own == 0) q0.push_back(w);
            else          q1.push_back(w);
            @(posedge clk);
            #1;
         end
         eng_out_valid = 1'b0;
         @(negedge clk);
         check({name, "_early_done"}, 32'({rsp1_done, rsp0_done}), 0);
         @(negedge clk);
      end
      check({name, "_done"}, 32'({rsp1_done, rsp0_done}), 32'(own_bits));
      check({name, "_err"}, 32'({rsp1_err, rsp0_err}), tmo ? 32'(own_bits) : 0);
      check({name, "_done_no_rsp"}, 32'({rsp1_valid, rsp0_valid}), 0);
      check({name, "_done_mode"}, 32'(eng_mode), 32'(mode));
      check({name, "_done_busy"}, 32'(busy), 1);
      @(negedge clk);
      check({name, "_idle_busy"}, 32'(busy), 0);
      check({name, "_idle_mode"}, 32'(eng_mode), 0);
      check({name, "_idle_done"}, 32'({rsp1_done, rsp0_done}), 0);
      check({name, "_drained"}, 32'(q0.size() + q1.size()), 0);
   endtask

   initial begin
      rst = 1'b1;
      req0_valid = 1'b0; req0_mode = '0; req0_data = '0;
      req1_valid = 1'b0; req1_mode = '0; req1_data = '0;
      eng_ready = 1'b0; eng_out = '0; eng_out_valid = 1'b0;
      #1;
      check("rst_in_valid", 32'(eng_in_valid), 0);
      check("rst_outputs", 32'({req1_pop, req0_pop, rsp1_valid, rsp0_valid,
                                 rsp1_done, rsp0_done, rsp1_err, rsp0_err, busy}), 0);
      check("rst_eng_mode", 32'(eng_mode), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Both pending right after reset, but the engine is not ready yet.
      req0_valid = 1'b1; req0_mode = 3'd3; req0_data = 3'd1;
      req1_valid = 1'b1; req1_mode = 3'd5; req1_data = 3'd4;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("notready_pop", 32'({req1_pop, req0_pop}), 0);
         check("notready_in_valid", 32'(eng_in_valid), 0);
         check("notready_busy", 32'(busy), 0);
      end
      eng_ready = 1'b1;
      run_job(0, 3'd3, 1'b0, 1, 6, 1'b0, 3'd1, "jobA");

      // Re-raise req0: pointer now favours req1.
      req0_valid = 1'b1; req0_mode = 3'd2; req0_data = 3'd0;
      run_job(1, 3'd5, 1'b0, 0, 4, 1'b0, 3'd4, "jobB");
      run_job(0, 3'd2, 1'b0, 3, 1, 1'b0, 3'd0, "jobC");

      req1_valid = 1'b1; req1_mode = 3'd6; req1_data = 3'd2;
      run_job(1, 3'd6, 1'b0, 0, 0, 1'b1, 3'd2, "jobD_timeout");

      // Engine chatter while idle and during the burst must be dropped.
      eng_out = 3'd5;
      eng_out_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("stray_idle_busy", 32'(busy), 0);
      end
      req0_valid = 1'b1; req0_mode = 3'd1; req0_data = 3'd3;
      run_job(0, 3'd1, 1'b1, 2, 3, 1'b0, 3'd3, "jobE_stray");

      // Reset in the middle of a req1 burst.
      req1_valid = 1'b1; req1_mode = 3'd4; req1_data = 3'd6;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #2;
      check("mid_send_in_valid", 32'(eng_in_valid), 1);
      check("mid_send_pop", 32'({req1_pop, req0_pop}), 2);
      dones_before = dones;
      rst = 1'b1;
      #1;
      check("rst_mid_in_valid", 32'(eng_in_valid), 0);
      check("rst_mid_pop", 32'({req1_pop, req0_pop}), 0);
      check("rst_mid_busy", 32'(busy), 0);
      check("rst_mid_mode", 32'(eng_mode), 0);
      @(negedge clk);
      check("rst_mid_done", 32'({rsp1_done, rsp0_done, rsp1_valid, rsp0_valid}), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      req1_data = 3'd6;
      req0_valid = 1'b1; req0_mode = 3'd7; req0_data = 3'd5;
      run_job(0, 3'd7, 1'b0, 0, 2, 1'b0, 3'd5, "jobF_after_rst");
      req1_valid = 1'b0;
      check("rst_no_done_pulse", 32'(dones), 32'(dones_before + 1));

      repeat (4) @(negedge clk);
      check("total_dones", 32'(dones), 6);
      check("final_busy", 32'(busy), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired before the sequence completed");
      $fatal(1, "watchdog");
   end

endmodule
